dds_phase_acc: RTL
==================

// Module: dds_phase_acc
// PURPOSE
//   DDS phase accumulator, the stage directly downstream of the clock divider.
//   Advances a phase register by a frequency tuning word (FTW) on each
//   divider sample tick and emits a registered LUT address for the sine ROM.
//   FTW and phase offset load over a valid/ready port, either immediately or
//   phase-continuously at the next accumulator wrap.
// PARAMETERS
//   ACC_W   32  accumulator and FTW width, bits
//   ADDR_W  10  sine LUT address width; must be <= ACC_W
// PORTS
//   clk         in   1       system clock
//   rst         in   1       synchronous, active-high reset
//   sample_en   in   1       1-cycle tick from the divider stage; advances phase
//   run         in   1       1 = accumulate; 0 = hold at zero
//   cfg_valid   in   1       config word valid
//   cfg_ready   out  1       config word accepted when valid & ready
//   cfg_ftw     in   ACC_W   new frequency tuning word
//   cfg_pofs    in   ADDR_W  new phase offset, added to the address
//   cfg_sync    in   1       0 = apply immediately; 1 = apply at the next wrap
//   phase_addr  out  ADDR_W  registered LUT address
//   addr_valid  out  1       1-cycle pulse when phase_addr updates
//   wrap        out  1       1-cycle pulse when the accumulator carries out
// BEHAVIOUR
//   Reset: acc=0, ftw_act=0, pofs_act=0, phase_addr=0, addr_valid=0, wrap=0.
//     State=IDLE. cfg_ready=1.
//   FSM states: IDLE, RUN, ARMED.
//   - IDLE: run=1 moves to RUN on the next cycle. acc and phase_addr stay 0.
//     sample_en is ignored.
//   - RUN: a cfg transfer with cfg_sync=1 moves to ARMED and stores
//     ftw_pend/pofs_pend. Any transfer with cfg_sync=0 loads ftw_act/pofs_act
//     on that edge.
//   - ARMED: a sample_en that carries out applies the pending FTW and offset
//     on the same edge, then returns to RUN.
//   - Any state: run=0 moves to IDLE on the next edge. That edge clears acc
//     and phase_addr and moves any pending word into the active registers.
//   cfg_ready = (state != ARMED), combinational from the state register.
//     In IDLE every transfer loads immediately, whatever cfg_sync says.
//   Accumulate: on an edge with sample_en=1 in RUN or ARMED:
//     {carry, acc} <= acc + ftw_act, width ACC_W+1, i.e. modulo 2^ACC_W.
//     phase_addr <= acc_next[ACC_W-1 -: ADDR_W] + pofs_act, modulo 2^ADDR_W.
//     addr_valid=1 and wrap=carry in the following cycle only.
//   Latency: sample_en at cycle N -> new phase_addr, addr_valid, wrap at N+1.
//   Simultaneous sample_en and immediate cfg transfer: the accumulate uses the
//     old ftw_act; the new FTW is used from the next tick.
//   Simultaneous ARMED wrap tick: that step uses the old FTW (phase-continuous).
//   ftw_act=0: acc holds, no wrap. addr_valid still pulses on each tick.
//   sample_en with run=0 or in IDLE: no pulses.
//   rst overrides everything, including mid-sweep and the ARMED state.
// CONFIGURATION
//   `DDS_SWEEP_EN` defined: adds these ports.
//     sweep_step  in   ACC_W  unsigned FTW increment
//     sweep_lim   in   ACC_W  unsigned FTW ceiling
//     sweep_done  out  1      level signal; reset value 0
//   - On each wrap in RUN: ftw_act <= min(ftw_act + sweep_step, sweep_lim).
//     The add is ACC_W+1 wide, so there is no overflow.
//   - sweep_done=1 while ftw_act == sweep_lim.
//   - A cfg load on the same edge as a sweep wrap takes priority over the sweep.
//   `DDS_SWEEP_EN` undefined: the sweep ports are absent and ftw_act changes
//     only through cfg.
// TESTING
//   T1: run=1, load ftw=0x4000_0000 (immediate), sample_en every cycle
//     -> phase_addr 0x100, 0x200, 0x300, 0x000; wrap only with 0x000.
//   T2: pofs=0x080 with T1 stimulus -> 0x180, 0x280, 0x380, 0x080.
//   T3: ftw=0x1000_0000 running; send ftw=0x4000_0000 with cfg_sync=1
//     -> cfg_ready=0 until the wrap; step sizes 0x040 before the wrap, 0x100 after.
//   T4: sample_en every 3rd cycle -> addr_valid exactly 1 cycle after each tick;
//     none otherwise.
//   T5: run dropped mid-count with a word pending -> phase_addr=0 next cycle;
//     pending FTW active on the next run.
//   T6 (DDS_SWEEP_EN): ftw=0x4000_0000, step=0x4000_0000, lim=0xA000_0000
//     -> FTW after successive wraps 0x8000_0000, then 0xA000_0000; sweep_done=1.

Source files
------------

// File: rtl/dds_phase_acc.sv
// -----------------------------------------------------------------------------
// dds_phase_acc
//   DDS phase accumulator. On each sample tick from the clock divider the
//   phase register advances by the active frequency tuning word (FTW), and a
//   registered sine-LUT address (top ADDR_W bits of the new phase plus a phase
//   offset) is emitted together with a one-cycle valid pulse and a wrap pulse
//   on accumulator carry-out.
//
//   New FTW / offset words arrive on a valid/ready port. They are applied
//   either immediately (cfg_sync=0) or phase-continuously at the next
//   accumulator wrap (cfg_sync=1). cfg_ready is low only while a word waits
//   for that wrap.
//
//   Optional feature macro: DDS_SWEEP_EN
//     When defined, every wrap in the RUN state raises the FTW by sweep_step,
//     saturating at sweep_lim; sweep_done is high while FTW equals sweep_lim.
//
// Ports
//   clk         in   1       system clock
//   rst         in   1       synchronous active-high reset
//   sample_en   in   1       tick from the divider; advances the phase
//   run         in   1       1 = accumulate, 0 = hold at zero
//   cfg_valid   in   1       config word valid
//   cfg_ready   out  1       config word accepted when valid & ready
//   cfg_ftw     in   ACC_W   new frequency tuning word
//   cfg_pofs    in   ADDR_W  new phase offset added to the address
//   cfg_sync    in   1       0 = apply now, 1 = apply at the next wrap
//   sweep_step  in   ACC_W   FTW increment per wrap     (DDS_SWEEP_EN only)
//   sweep_lim   in   ACC_W   FTW ceiling                (DDS_SWEEP_EN only)
//   sweep_done  out  1       FTW has reached sweep_lim  (DDS_SWEEP_EN only)
//   phase_addr  out  ADDR_W  registered LUT address
//   addr_valid  out  1       pulse when phase_addr updates
//   wrap        out  1       pulse when the accumulator carries out
// -----------------------------------------------------------------------------
module dds_phase_acc #(
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_en,
    input  logic              run,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ACC_W-1:0]  cfg_ftw,
    input  logic [ADDR_W-1:0] cfg_pofs,
    input  logic              cfg_sync,
`ifdef DDS_SWEEP_EN
    input  logic [ACC_W-1:0]  sweep_step,
    input  logic [ACC_W-1:0]  sweep_lim,
    output logic              sweep_done,
`endif
    output logic [ADDR_W-1:0] phase_addr,
    output logic              addr_valid,
    output logic              wrap
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_ARMED = 2'd2;

    logic [1:0]        r_state;
    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  r_ftw_act;
    logic [ADDR_W-1:0] r_pofs_act;
    logic [ACC_W-1:0]  r_ftw_pend;
    logic [ADDR_W-1:0] r_pofs_pend;
    logic [ADDR_W-1:0] r_phase_addr;
    logic              r_addr_valid;
    logic              r_wrap;

    logic [1:0]        w_state_next;
    logic [ACC_W-1:0]  w_acc_next;
    logic [ACC_W-1:0]  w_ftw_next;
    logic [ADDR_W-1:0] w_pofs_next;
    logic [ACC_W-1:0]  w_ftw_pend_next;
    logic [ADDR_W-1:0] w_pofs_pend_next;
    logic [ADDR_W-1:0] w_addr_next;
    logic              w_valid_next;
    logic              w_wrap_next;

    logic              w_xfer;
    logic [ACC_W:0]    w_sum;        // carry in the top bit
    logic [ADDR_W-1:0] w_addr_step;  // address for the phase after this tick

    assign cfg_ready   = (r_state != ST_ARMED);
    assign w_xfer      = cfg_valid & cfg_ready;
    assign w_sum       = {1'b0, r_acc} + {1'b0, r_ftw_act};
    assign w_addr_step = w_sum[ACC_W-1 -: ADDR_W] + r_pofs_act;

`ifdef DDS_SWEEP_EN
    logic              r_sweep_done;
    logic [ACC_W:0]    w_sweep_sum;
    logic [ACC_W-1:0]  w_sweep_ftw;

    // One bit wider than the FTW so the sum can never wrap below the limit.
    assign w_sweep_sum = {1'b0, r_ftw_act} + {1'b0, sweep_step};
    assign w_sweep_ftw = (w_sweep_sum > {1'b0, sweep_lim}) ? sweep_lim
                                                           : w_sweep_sum[ACC_W-1:0];
    assign sweep_done  = r_sweep_done;
`endif

    always_comb begin
        w_state_next     = r_state;
        w_acc_next       = r_acc;
        w_ftw_next       = r_ftw_act;
        w_pofs_next      = r_pofs_act;
        w_ftw_pend_next  = r_ftw_pend;
        w_pofs_pend_next = r_pofs_pend;
        w_addr_next      = r_phase_addr;
        w_valid_next     = 1'b0;
        w_wrap_next      = 1'b0;

        if (!run) begin
            // Stopping flushes the phase and promotes any waiting word so the
            // next run starts with it; a word offered now loads directly.
            w_state_next = ST_IDLE;
            w_acc_next   = '0;
            w_addr_next  = '0;
            if (r_state == ST_ARMED) begin
                w_ftw_next  = r_ftw_pend;
                w_pofs_next = r_pofs_pend;
            end
            if (w_xfer) begin
                w_ftw_next  = cfg_ftw;
                w_pofs_next = cfg_pofs;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Nothing to keep phase-continuous yet: always load now.
                    w_state_next = ST_RUN;
                    if (w_xfer) begin
                        w_ftw_next  = cfg_ftw;
                        w_pofs_next = cfg_pofs;
                    end
                end
                ST_RUN, ST_ARMED: begin
                    if (sample_en) begin
                        // This step always uses the FTW/offset active before
                        // the edge; any change below takes effect next tick.
                        w_acc_next   = w_sum[ACC_W-1:0];
                        w_addr_next  = w_addr_step;
                        w_valid_next = 1'b1;
                        w_wrap_next  = w_sum[ACC_W];
                        if (w_sum[ACC_W] && (r_state == ST_ARMED)) begin
                            w_ftw_next   = r_ftw_pend;
                            w_pofs_next  = r_pofs_pend;
                            w_state_next = ST_RUN;
                        end
`ifdef DDS_SWEEP_EN
                        if (w_sum[ACC_W] && (r_state == ST_RUN)) begin
                            w_ftw_next = w_sweep_ftw;
                        end
`endif
                    end
                    // Only reachable from RUN (cfg_ready is low in ARMED); an
                    // immediate load overrides a sweep step on the same edge.
                    if (w_xfer) begin
                        if (cfg_sync) begin
                            w_ftw_pend_next  = cfg_ftw;
                            w_pofs_pend_next = cfg_pofs;
                            w_state_next     = ST_ARMED;
                        end else begin
                            w_ftw_next  = cfg_ftw;
                            w_pofs_next = cfg_pofs;
                        end
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_acc        <= '0;
            r_ftw_act    <= '0;
            r_pofs_act   <= '0;
            r_ftw_pend   <= '0;
            r_pofs_pend  <= '0;
            r_phase_addr <= '0;
            r_addr_valid <= 1'b0;
            r_wrap       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_acc        <= w_acc_next;
            r_ftw_act    <= w_ftw_next;
            r_pofs_act   <= w_pofs_next;
            r_ftw_pend   <= w_ftw_pend_next;
            r_pofs_pend  <= w_pofs_pend_next;
            r_phase_addr <= w_addr_next;
            r_addr_valid <= w_valid_next;
            r_wrap       <= w_wrap_next;
        end
    end

`ifdef DDS_SWEEP_EN
    // Registered from the next FTW so it tracks r_ftw_act cycle for cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sweep_done <= 1'b0;
        end else begin
            r_sweep_done <= (w_ftw_next == sweep_lim);
        end
    end
`endif

    assign phase_addr = r_phase_addr;
    assign addr_valid = r_addr_valid;
    assign wrap       = r_wrap;

endmodule
